dmem_responder: RTL and testbench

Data-memory responder serving load/store requests issued by the pipelined MIPS core's memory stage. Holds a word-addressed RAM, answers each request after a programmable number of wait cycles, and raises a stall to the hazard unit while an access is outstanding. Sits beside the datapath's M stage. The hazard unit ORs `stallM` into its freeze of the F/D/E/M pipeline registers.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/dmem_ram.sv | 37 +++
 rtl/dmem_responder.sv | 172 +++++++++++++++++
 tb/tb_dmem_responder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS core's memory-side blocks.
//   dmem_state_t  : responder FSM states (IDLE, WAIT, DONE)
//   MMIO_OUT_ADDR : byte address of the MMIO output register (store target)
//   MMIO_CNT_ADDR : byte address of the free-running cycle counter (load source)
//   isAligned()   : word-alignment test for a byte address
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam logic [31:0] MMIO_OUT_ADDR = 32'hFFFF_FFF0;
    localparam logic [31:0] MMIO_CNT_ADDR = 32'hFFFF_FFF4;

    function automatic logic isAligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// -----------------------------------------------------------------------------
// dmem_ram
// Single-port synchronous RAM, DEPTH x 32. One access per enabled edge:
// a write when we=1, otherwise a read whose data is registered on that edge
// and held until the next enabled read. Contents are never reset.
// Ports:
//   clk   in  1          : clock
//   en    in  1          : access enable
//   we    in  1          : 1 = write, 0 = read (qualified by en)
//   addr  in  log2(DEPTH): word index
//   wdata in  32         : write data
//   rdata out 32         : registered read data
// -----------------------------------------------------------------------------
module dmem_ram #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for the MIPS M stage. Accepts an aligned load/store,
// waits LATENCY+1 cycles in WAIT, performs the access on the final WAIT edge,
// then spends one DONE cycle with the stall released so the pipeline advances.
// Misaligned requests only raise misalignM and are otherwise dropped.
//
// Optional feature: define DMEM_MMIO_EN to decode
//   MMIO_OUT_ADDR (store -> io_out) and MMIO_CNT_ADDR (load <- cycle counter).
// Without it those addresses alias into RAM and io_out is tied to 0.
//
// Ports:
//   clk        in  1  : clock
//   reset      in  1  : asynchronous active-low reset
//   reqM       in  1  : M-stage request valid, held until the pipeline advances
//   memwriteM  in  1  : 1 = store, 0 = load
//   aluoutM    in  32 : byte address
//   writedataM in  32 : store data
//   readdataM  out 32 : load result (valid in DONE, holds otherwise)
//   stallM     out 1  : access outstanding, pipeline must freeze
//   misalignM  out 1  : request with a non-word-aligned address
//   io_out     out 32 : MMIO output register
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqM,
    input  logic        memwriteM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        misalignM,
    output logic [31:0] io_out
);
    import mips_pkg::*;

    localparam int AW = $clog2(DEPTH);

    dmem_state_t   state;
    logic [2:0]    waitCnt;
    logic          writeLat;
    logic          mmioOutLat;
    logic          mmioCntLat;
    logic [AW-1:0] idxLat;
    logic [31:0]   dataLat;

    // readdataM is either the RAM's registered output or holdData (reset
    // value / counter snapshot); useRam selects which one the last load filled.
    logic          useRam;
    logic [31:0]   holdData;
    logic [31:0]   ramRdata;

    logic          aligned;
    logic          accept;
    logic          commit;
    logic          ramEn;
    logic          decOut;
    logic          decCnt;
    logic [31:0]   cycleVal;

    // Address bits above the RAM index are deliberately ignored (wrap-around).
    logic          unusedAddrBits;
    assign unusedAddrBits = ^aluoutM[31:AW+2];

    assign aligned = isAligned(aluoutM);
    assign accept  = (state == IDLE) && reqM && aligned;
    assign commit  = (state == WAIT) && (waitCnt == 3'd0);

    // Gating with reset keeps both flags low while reset is held, even if
    // the core keeps reqM asserted.
    assign stallM    = reset && (accept || (state == WAIT));
    assign misalignM = reset && (state == IDLE) && reqM && !aligned;

    assign readdataM = useRam ? ramRdata : holdData;

`ifdef DMEM_MMIO_EN
    logic [31:0] cycleCnt;
    logic [31:0] ioReg;

    assign decOut   = (aluoutM == MMIO_OUT_ADDR);
    assign decCnt   = (aluoutM == MMIO_CNT_ADDR);
    assign cycleVal = cycleCnt;
    assign io_out   = ioReg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycleCnt <= '0;
            ioReg    <= '0;
        end else begin
            cycleCnt <= cycleCnt + 32'd1;
            if (commit && writeLat && mmioOutLat) begin
                ioReg <= dataLat;
            end
        end
    end
`else
    assign decOut   = 1'b0;
    assign decCnt   = 1'b0;
    assign cycleVal = '0;
    assign io_out   = '0;
`endif

    // MMIO accesses never touch the RAM.
    assign ramEn = commit && !mmioOutLat && !mmioCntLat;

    // ---- request capture: address/data are sampled once on accept ----
    always_ff @(posedge clk) begin
        if (accept) begin
            idxLat  <= aluoutM[AW+1:2];
            dataLat <= writedataM;
        end
    end

    // ---- control FSM ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            waitCnt    <= 3'd0;
            writeLat   <= 1'b0;
            mmioOutLat <= 1'b0;
            mmioCntLat <= 1'b0;
            useRam     <= 1'b0;
            holdData   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= WAIT;
                        waitCnt    <= 3'(LATENCY);
                        writeLat   <= memwriteM;
                        mmioOutLat <= decOut;
                        mmioCntLat <= decCnt;
                    end
                end
                WAIT: begin
                    if (waitCnt == 3'd0) begin
                        state <= DONE;
                        if (!writeLat) begin
                            if (mmioCntLat) begin
                                useRam   <= 1'b0;
                                holdData <= cycleVal;
                            end else begin
                                useRam   <= 1'b1;
                            end
                        end
                    end else begin
                        waitCnt <= waitCnt - 3'd1;
                    end
                end
                // reqM is still the request just served, so it is ignored here.
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    dmem_ram #(
        .DEPTH (DEPTH)
    ) uRam (
        .clk   (clk),
        .en    (ramEn),
        .we    (writeLat),
        .addr  (idxLat),
        .wdata (dataLat),
        .rdata (ramRdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Scoreboard bench for dmem_responder. Two instances share clock and reset:
//   u2 : DEPTH=64, LATENCY=2 (functional, wrap, misalign, reset, MMIO/alias)
//   u0 : DEPTH=64, LATENCY=0 (back-to-back loads)
// Stimulus pushes the expected response into a per-instance queue; monitor
// threads pop and compare whenever the instance completes an access (first
// non-stalled cycle after a stall) or flags a misaligned request.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    typedef struct {
        bit          mis;
        bit          chk;
        logic [31:0] data;
        int          len;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        req2 = 1'b0, wr2 = 1'b0;
    logic [31:0] addr2 = '0, wdata2 = '0;
    logic [31:0] rd2, io2;
    logic        stall2, mis2;

    logic        req0 = 1'b0, wr0 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic [31:0] rd0, io0;
    logic        stall0, mis0;

    int nTests = 0;
    int nFail  = 0;
    int cyc    = 0;

    exp_t q2[$];
    exp_t q0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH(64), .LATENCY(2)) u2 (
        .clk(clk), .reset(reset), .reqM(req2), .memwriteM(wr2),
        .aluoutM(addr2), .writedataM(wdata2), .readdataM(rd2),
        .stallM(stall2), .misalignM(mis2), .io_out(io2)
    );

    dmem_responder #(.DEPTH(64), .LATENCY(0)) u0 (
        .clk(clk), .reset(reset), .reqM(req0), .memwriteM(wr0),
        .aluoutM(addr0), .writedataM(wdata0), .readdataM(rd0),
        .stallM(stall0), .misalignM(mis0), .io_out(io0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic exp_t mkExp(input bit mis, input bit c, input logic [31:0] d, input int len);
        exp_t e;
        e.mis = mis; e.chk = c; e.data = d; e.len = len;
        return e;
    endfunction

    task automatic monitor2();
        int   sc;
        exp_t e;
        sc = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                sc = 0;
            end else if (mis2) begin
                if (q2.size() == 0) begin
                    nTests++; nFail++;
                    $display("FAIL u2_misalign_unexpected: got misalignM=1, required no event");
                end else begin
                    e = q2.pop_front();
                    chk("u2_misalign_expected", {31'd0, e.mis}, 32'd1);
                    chk("u2_misalign_stall", {31'd0, stall2}, 32'd0);
                end
            end else if (stall2) begin
                sc++;
            end else if (sc > 0) begin
                if (q2.size() == 0) begin
                    nTests++; nFail++;
                    $display("FAIL u2_done_unexpected: got completion, required none");
                end else begin
                    e = q2.pop_front();
                    chk("u2_done_not_misalign", {31'd0, e.mis}, 32'd0);
                    chk("u2_stall_len", sc, e.len);
                    if (e.chk) chk("u2_readdata", rd2, e.data);
                end
                sc = 0;
            end
        end
    endtask

    task automatic monitor0();
        int   sc;
        exp_t e;
        sc = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                sc = 0;
            end else if (mis0) begin
                nTests++; nFail++;
                $display("FAIL u0_misalign_unexpected: got misalignM=1, required 0");
            end else if (stall0) begin
                sc++;
            end else if (sc > 0) begin
                if (q0.size() == 0) begin
                    nTests++; nFail++;
                    $display("FAIL u0_done_unexpected: got completion, required none");
                end else begin
                    e = q0.pop_front();
                    chk("u0_stall_len", sc, e.len);
                    if (e.chk) chk("u0_readdata", rd0, e.data);
                end
                sc = 0;
            end
        end
    endtask

    // Waits for the first non-stalled negedge sample (DONE, or the request
    // cycle itself for a misaligned address), bounded.
    task automatic waitDone2();
        bit seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stall2) begin seen = 1; break; end
        end
        chk("u2_done_within_bound", {31'd0, seen}, 32'd1);
    endtask

    task automatic waitDone0();
        bit seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stall0) begin seen = 1; break; end
        end
        chk("u0_done_within_bound", {31'd0, seen}, 32'd1);
    endtask

    task automatic acc2(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        req2 = 1'b1; wr2 = w; addr2 = a; wdata2 = d;
        waitDone2();
        @(posedge clk); #1;
        req2 = 1'b0;
    endtask

    task automatic acc0(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d;
        waitDone0();
        @(posedge clk); #1;
        req0 = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1, d2, tStart;
        logic [31:0] v1, v2;

        fork
            monitor2();
            monitor0();
        join_none

        // Reset held with requests active: flags must stay low.
        req2 = 1'b1; wr2 = 1'b0; addr2 = 32'h42;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_misalign_gated", {31'd0, mis2}, 32'd0);
        chk("rst_stall_gated_mis", {31'd0, stall2}, 32'd0);
        addr2 = 32'h40;
        @(negedge clk);
        chk("rst_stall_gated", {31'd0, stall2}, 32'd0);
        chk("rst_readdata", rd2, 32'h0);
        chk("rst_io_out", io2, 32'h0);
        chk("rst_readdata_u0", rd0, 32'h0);
        @(posedge clk); #1;
        req2 = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Store then load, LATENCY=2: 4 stall cycles each.
        q2.push_back(mkExp(0, 0, 32'h0, 4));
        acc2(1'b1, 32'h40, 32'hDEAD_BEEF);
        q2.push_back(mkExp(0, 1, 32'hDEAD_BEEF, 4));
        acc2(1'b0, 32'h40, 32'h0);

        // Wrap: 0x100 aliases index 0 when DEPTH=64.
        q2.push_back(mkExp(0, 0, 32'h0, 4));
        acc2(1'b1, 32'h100, 32'h0000_1234);
        q2.push_back(mkExp(0, 1, 32'h0000_1234, 4));
        acc2(1'b0, 32'h000, 32'h0);

        // Misaligned store: flag only, no write, readdataM unchanged.
        q2.push_back(mkExp(1, 0, 32'h0, 0));
        acc2(1'b1, 32'h42, 32'h9999_9999);
        chk("misalign_readdata_held", rd2, 32'h0000_1234);
        q2.push_back(mkExp(0, 1, 32'hDEAD_BEEF, 4));
        acc2(1'b0, 32'h40, 32'h0);

        // Reset during a pending store: old value survives.
        q2.push_back(mkExp(0, 0, 32'h0, 4));
        acc2(1'b1, 32'h80, 32'h0BAD_F00D);
        @(posedge clk); #1;
        req2 = 1'b1; wr2 = 1'b1; addr2 = 32'h80; wdata2 = 32'h0000_5555;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_stall", {31'd0, stall2}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("reset_stall_low", {31'd0, stall2}, 32'd0);
        chk("reset_misalign_low", {31'd0, mis2}, 32'd0);
        chk("reset_readdata_zero", rd2, 32'h0);
        @(posedge clk); #1;
        req2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        q2.push_back(mkExp(0, 1, 32'h0BAD_F00D, 4));
        acc2(1'b0, 32'h80, 32'h0);

        // LATENCY=0 back-to-back loads.
        q0.push_back(mkExp(0, 0, 32'h0, 2));
        acc0(1'b1, 32'h40, 32'h1111_1111);
        q0.push_back(mkExp(0, 0, 32'h0, 2));
        acc0(1'b1, 32'h00, 32'h2222_2222);
        q0.push_back(mkExp(0, 1, 32'h1111_1111, 2));
        q0.push_back(mkExp(0, 1, 32'h2222_2222, 2));
        @(posedge clk); #1;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h40;
        waitDone0();
        d1 = cyc;
        @(posedge clk); #1;
        addr0 = 32'h00;
        waitDone0();
        d2 = cyc;
        chk("b2b_done_gap", d2 - d1, 32'd3);
        @(posedge clk); #1;
        req0 = 1'b0;

`ifdef DMEM_MMIO_EN
        // MMIO store and cycle-counter reads.
        q2.push_back(mkExp(0, 0, 32'h0, 4));
        acc2(1'b1, 32'hFFFF_FFF0, 32'h0000_00A5);
        chk("mmio_io_out", io2, 32'h0000_00A5);
        q2.push_back(mkExp(0, 0, 32'h0, 4));
        q2.push_back(mkExp(0, 0, 32'h0, 4));
        @(posedge clk); #1;
        tStart = cyc;
        req2 = 1'b1; wr2 = 1'b0; addr2 = 32'hFFFF_FFF4;
        waitDone2();
        v1 = rd2;
        @(posedge clk); #1;
        req2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cyc == tStart + 10) break;
            @(posedge clk); #1;
        end
        req2 = 1'b1;
        waitDone2();
        v2 = rd2;
        @(posedge clk); #1;
        req2 = 1'b0;
        chk("mmio_cnt_delta", v2 - v1, 32'd10);
`else
        // Without MMIO, 0xFFFF_FFF0 aliases index 0x3C (byte 0xF0).
        q2.push_back(mkExp(0, 0, 32'h0, 4));
        acc2(1'b1, 32'hFFFF_FFF0, 32'h0000_00A5);
        chk("alias_io_out_zero", io2, 32'h0);
        q2.push_back(mkExp(0, 1, 32'h0000_00A5, 4));
        acc2(1'b0, 32'h0000_00F0, 32'h0);
`endif

        repeat (4) @(posedge clk);
        chk("u2_queue_drained", q2.size(), 32'd0);
        chk("u0_queue_drained", q0.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
